dpll_ctrl: RTL and testbench

Sequencing controller for the digital PLL. It holds the PLL in reset, releases it, and measures XOR phase error per fixed window to decide lock. It gates the PLL outputs until lock and performs freq_select changes through a request handshake with controlled re-acquisition. Sits between the management registers and the PLL's reset and freq_select pins.

---
 rtl/dpll_pkg.sv | 22 ++
 rtl/dpll_phase_meter.sv | 63 ++++++
 rtl/dpll_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dpll_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// dpll_pkg: state encoding, freq_select codes and width helper shared by
// dpll_ctrl and dpll_phase_meter.
package dpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLL_RST = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } dpll_state_e;

    localparam logic [1:0] FSEL_X8 = 2'b00;
    localparam logic [1:0] FSEL_X4 = 2'b01;
    localparam logic [1:0] FSEL_X2 = 2'b10;

    // Bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dpll_phase_meter.sv
// dpll_phase_meter: synchronizes the reference and feedback clocks, and
// counts XOR phase-error cycles over fixed windows. done_o pulses on the
// last cycle of each window with count_o holding that window's total,
// including the last cycle's sample.
module dpll_phase_meter
    import dpll_pkg::*;
#(
    parameter int unsigned WIN_CYCLES = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            run_i,
    input  logic                            restart_i,
    input  logic                            clk_fin_i,
    input  logic                            pll_fout_i,
    output logic                            done_o,
    output logic [cnt_w(WIN_CYCLES)-1:0]    count_o
);

    localparam int unsigned CW = cnt_w(WIN_CYCLES);
    localparam int unsigned PW = cnt_w(WIN_CYCLES - 1);
    localparam logic [CW-1:0] WIN_SAT  = CW'(WIN_CYCLES);
    localparam logic [PW-1:0] POS_LAST = PW'(WIN_CYCLES - 1);

    logic [1:0]    fin_sync_q;
    logic [1:0]    fout_sync_q;
    logic [PW-1:0] pos_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_sum;
    logic          err;

    assign err     = fin_sync_q[1] ^ fout_sync_q[1];
    assign acc_sum = (acc_q == WIN_SAT) ? acc_q : acc_q + CW'(err);
    assign done_o  = run_i && (pos_q == POS_LAST);
    assign count_o = acc_sum;

    // Two-flop synchronizers for both asynchronous clock inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fin_sync_q  <= '0;
            fout_sync_q <= '0;
        end else begin
            fin_sync_q  <= {fin_sync_q[0], clk_fin_i};
            fout_sync_q <= {fout_sync_q[0], pll_fout_i};
        end
    end

    // Window position and error accumulator; cleared when idle, on restart
    // and after each completed window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q <= '0;
            acc_q <= '0;
        end else if (!run_i || restart_i || done_o) begin
            pos_q <= '0;
            acc_q <= '0;
        end else begin
            pos_q <= pos_q + 1'b1;
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/dpll_ctrl.sv
// dpll_ctrl: PLL reset sequencing, lock detection and freq_select handshake.
// Optional loss-of-lock monitor enabled by defining DPLL_CTRL_LOSS_MON_EN.
module dpll_ctrl
    import dpll_pkg::*;
#(
    parameter int unsigned RST_CYCLES      = 16,
    parameter int unsigned WIN_CYCLES      = 64,
    parameter int unsigned LOCK_THRESH     = 8,
    parameter int unsigned LOCK_WINDOWS    = 4,
    parameter int unsigned TIMEOUT_WINDOWS = 32
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic                         enable_i,
    input  logic [1:0]                   freq_req_i,
    input  logic                         freq_req_valid_i,
    output logic                         freq_req_ready_o,
    input  logic                         clk_fin_i,
    input  logic                         pll_fout_i,
    output logic                         pll_rst_o,
    output logic [1:0]                   pll_freq_sel_o,
    output logic                         out_gate_o,
    output logic                         locked_o,
    output logic                         fault_o,
    output logic [2:0]                   state_o,
    output logic [cnt_w(WIN_CYCLES)-1:0] err_count_o
);

    localparam int unsigned EW = cnt_w(WIN_CYCLES);
    localparam int unsigned RW = cnt_w(RST_CYCLES - 1);
    localparam int unsigned GW = cnt_w(LOCK_WINDOWS);
    localparam int unsigned TW = cnt_w(TIMEOUT_WINDOWS);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [GW-1:0] LOCK_N    = GW'(LOCK_WINDOWS);
    localparam logic [TW-1:0] TIMEOUT_N = TW'(TIMEOUT_WINDOWS);
    localparam logic [EW-1:0] THRESH_N  = EW'(LOCK_THRESH);

    dpll_state_e   state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [GW-1:0] good_q, good_d, good_nxt;
    logic [TW-1:0] total_q, total_d, total_nxt;
    logic [EW-1:0] errc_q, errc_d;
    logic          pll_rst_q, lock_q, fault_q;
    logic          win_done, restart, accept, meter_run;
    logic [EW-1:0] win_err;
`ifdef DPLL_CTRL_LOSS_MON_EN
    logic [GW-1:0] bad_q, bad_d;
`endif

    assign freq_req_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOCKED);
    assign accept           = freq_req_valid_i && freq_req_ready_o;
    assign meter_run        = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
    assign good_nxt         = (win_err <= THRESH_N) ? good_q + 1'b1 : '0;
    assign total_nxt        = total_q + 1'b1;

    assign pll_rst_o      = pll_rst_q;
    assign pll_freq_sel_o = sel_q;
    assign out_gate_o     = lock_q;
    assign locked_o       = lock_q;
    assign fault_o        = fault_q;
    assign state_o        = state_q;
    assign err_count_o    = errc_q;

    dpll_phase_meter #(
        .WIN_CYCLES(WIN_CYCLES)
    ) u_meter (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .run_i     (meter_run),
        .restart_i (restart),
        .clk_fin_i (clk_fin_i),
        .pll_fout_i(pll_fout_i),
        .done_o    (win_done),
        .count_o   (win_err)
    );

    // Next-state, lock/timeout evaluation and request handling.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rst_cnt_d = rst_cnt_q;
        good_d    = good_q;
        total_d   = total_q;
        errc_d    = errc_q;
`ifdef DPLL_CTRL_LOSS_MON_EN
        bad_d     = bad_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                rst_cnt_d = '0;
                if (enable_i) state_d = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = ST_ACQUIRE;
                else rst_cnt_d = rst_cnt_q + 1'b1;
            end
            ST_ACQUIRE: begin
                if (win_done) begin
                    good_d  = good_nxt;
                    total_d = total_nxt;
                    if (good_nxt == LOCK_N) state_d = ST_LOCKED;
                    else if (total_nxt == TIMEOUT_N) state_d = ST_FAULT;
                end
            end
            ST_LOCKED: begin
                if (accept && (freq_req_i != sel_q)) state_d = ST_ACQUIRE;
`ifdef DPLL_CTRL_LOSS_MON_EN
                if (win_done) begin
                    bad_d = (win_err > THRESH_N) ? bad_q + 1'b1 : '0;
                    if (bad_d == LOCK_N) state_d = ST_ACQUIRE;
                end
`endif
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
        endcase
        if (win_done) errc_d = win_err;
        if (accept) sel_d = freq_req_i;
        if (!enable_i) state_d = ST_IDLE;
        // Any entry into ACQUIRE (PLL reset, freq change, lock loss) restarts
        // the window and the lock/timeout bookkeeping.
        restart = (state_d == ST_ACQUIRE) && (state_q != ST_ACQUIRE);
        if (restart) begin
            good_d  = '0;
            total_d = '0;
        end
`ifdef DPLL_CTRL_LOSS_MON_EN
        if ((state_d == ST_LOCKED) && (state_q != ST_LOCKED)) bad_d = '0;
`endif
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            sel_q     <= FSEL_X8;
            rst_cnt_q <= '0;
            good_q    <= '0;
            total_q   <= '0;
            errc_q    <= '0;
            pll_rst_q <= 1'b1;
            lock_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rst_cnt_q <= rst_cnt_d;
            good_q    <= good_d;
            total_q   <= total_d;
            errc_q    <= errc_d;
            pll_rst_q <= (state_d == ST_IDLE) || (state_d == ST_PLL_RST) ||
                         (state_d == ST_FAULT);
            lock_q    <= (state_d == ST_LOCKED);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

`ifdef DPLL_CTRL_LOSS_MON_EN
    // Consecutive bad-window count while locked.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) bad_q <= '0;
        else            bad_q <= bad_d;
    end
`endif

endmodule

// File: tb/tb_dpll_ctrl.sv
// tb_dpll_ctrl: randomized and directed stimulus for dpll_ctrl, compared
// every cycle against a behavioural model, plus literal timing checks.
module tb_dpll_ctrl;
    import dpll_pkg::*;

    localparam int RST = 16, WIN = 64, TH = 8, LW = 4, TO = 32;

    logic       clk = 0, rst_n = 1, en = 0, valid = 0, fin = 0, fout = 0;
    logic [1:0] req = '0;
    logic       ready, pll_rst, gate, locked, fault;
    logic [1:0] sel;
    logic [2:0] st;
    logic [6:0] errc;

    int n_chk = 0, n_pass = 0, idx = 0, w = 0;
    logic [63:0] pat = '0;
    bit  rnd_mode = 0, eb = 0;
    int  pct = 0;

    // Behavioural model: plain integer bookkeeping of the sequencing rules.
    int m_st = 0, m_sel = 0, m_errc = 0, m_rcnt = 0, m_wpos = 0, m_wacc = 0;
    int m_good = 0, m_total = 0, m_bad = 0;
    bit m_f1 = 0, m_f2 = 0, m_o1 = 0, m_o2 = 0;

    dpll_ctrl #(
        .RST_CYCLES(RST), .WIN_CYCLES(WIN), .LOCK_THRESH(TH),
        .LOCK_WINDOWS(LW), .TIMEOUT_WINDOWS(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(en),
        .freq_req_i(req), .freq_req_valid_i(valid), .freq_req_ready_o(ready),
        .clk_fin_i(fin), .pll_fout_i(fout), .pll_rst_o(pll_rst),
        .pll_freq_sel_o(sel), .out_gate_o(gate), .locked_o(locked),
        .fault_o(fault), .state_o(st), .err_count_o(errc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] mkpat(input int n);
        logic [63:0] p = '0;
        for (int i = 0; i < n; i++) p[i] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_errc = 0; m_rcnt = 0; m_wpos = 0; m_wacc = 0;
        m_good = 0; m_total = 0; m_bad = 0;
        m_f1 = 0; m_f2 = 0; m_o1 = 0; m_o2 = 0;
    endtask

    task automatic model_step();
        int err, acc, nst;
        bit done, accept, measuring;
        err = m_f2 ^ m_o2;
        m_f2 = m_f1; m_f1 = fin; m_o2 = m_o1; m_o1 = fout;
        acc = m_wacc + err;
        if (acc > WIN) acc = WIN;
        measuring = (m_st == 2) || (m_st == 3);
        done = measuring && (m_wpos == WIN - 1);
        accept = valid && ((m_st == 0) || (m_st == 3));
        nst = m_st;
        if (m_st == 0) begin
            m_rcnt = 0;
            if (en) nst = 1;
        end else if (m_st == 1) begin
            if (m_rcnt == RST - 1) nst = 2; else m_rcnt++;
        end else if (m_st == 2 && done) begin
            m_good = (acc <= TH) ? m_good + 1 : 0;
            m_total++;
            if (m_good == LW) nst = 3;
            else if (m_total == TO) nst = 4;
        end else if (m_st == 3) begin
            if (accept && (int'(req) != m_sel)) nst = 2;
`ifdef DPLL_CTRL_LOSS_MON_EN
            if (done) begin
                m_bad = (acc > TH) ? m_bad + 1 : 0;
                if (m_bad == LW) nst = 2;
            end
`endif
        end
        if (done) m_errc = acc;
        if (accept) m_sel = int'(req);
        if (!en) nst = 0;
        if (nst == 2 && m_st != 2) begin
            m_wpos = 0; m_wacc = 0; m_good = 0; m_total = 0;
        end else if (measuring && !done) begin
            m_wpos++; m_wacc = acc;
        end else begin
            m_wpos = 0; m_wacc = 0;
        end
        if (nst == 3 && m_st != 3) m_bad = 0;
        m_st = nst;
    endtask

    // Compare process: model advances on each edge, DUT checked 1 unit later.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset(); else model_step();
        #1;
        chk("state", int'(st), m_st);
        chk("pll_rst", int'(pll_rst), int'(m_st == 0 || m_st == 1 || m_st == 4));
        chk("sel", int'(sel), m_sel);
        chk("gate", int'(gate), int'(m_st == 3));
        chk("locked", int'(locked), int'(m_st == 3));
        chk("fault", int'(fault), int'(m_st == 4));
        chk("err_count", int'(errc), m_errc);
        chk("ready", int'(ready), int'(m_st == 0 || m_st == 3));
    end

    // Phase-error generator: 64-periodic pattern or random density.
    initial forever begin
        @(negedge clk);
        idx++;
        if (rnd_mode) eb = ($urandom_range(0, 99) < pct);
        else eb = pat[idx % 64];
        fin = 1'($urandom_range(0, 1));
        fout = fin ^ eb;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm, output int waited);
        waited = 0;
        while (int'(st) != s && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk(nm, int'(st), s);
    endtask

    task automatic request(input logic [1:0] code, input int budget, output int waited);
        valid = 1; req = code; waited = 0;
        while (!ready && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready", int'(ready), 1);
        @(negedge clk);
        valid = 0;
    endtask

    task automatic restart_run();
        en = 0;
        tick(2);
        en = 1;
        wait_state(1, 4, "enter_pll_rst", w);
    endtask

    initial begin
        #1 rst_n = 0;
        #2;
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_state", int'(st), 0);
        chk("rst_locked", int'(locked), 0);
        @(negedge clk) rst_n = 1;

        // Clean clocks: 16 reset cycles then lock after 4 windows.
        pat = '0;
        restart_run();
        wait_state(2, 40, "reach_acquire", w);
        chk("pll_rst_cycles", w, 16);
        chk("pll_rst_low", int'(pll_rst), 0);
        wait_state(3, 400, "lock_clean", w);
        chk("lock_cycles", w, 256);
        chk("lock_err", int'(errc), 0);

        // 32 err per window: timeout after 32 windows, cleared by disable.
        pat = mkpat(32);
        restart_run();
        wait_state(2, 40, "reach_acquire2", w);
        wait_state(4, 2200, "fault_32", w);
        chk("fault_cycles", w, 2048);
        chk("fault_err", int'(errc), 32);
        en = 0;
        tick(1);
        chk("fault_clr_state", int'(st), 0);
        chk("fault_clr", int'(fault), 0);

        // 9 err per window never locks; exactly 8 err locks in 4 windows.
        pat = mkpat(9);
        restart_run();
        wait_state(2, 40, "reach_acquire3", w);
        wait_state(4, 2200, "fault_9", w);
        chk("fault9_cycles", w, 2048);
        pat = mkpat(8);
        restart_run();
        wait_state(2, 40, "reach_acquire4", w);
        wait_state(3, 400, "lock_8", w);
        chk("lock8_cycles", w, 256);
        chk("lock8_err", int'(errc), 8);

        // Random error density, enables and requests.
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) pct = $urandom_range(8, 18);
            if (en && $urandom_range(0, 499) == 0) en = 0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1;
            valid = ($urandom_range(0, 49) == 0);
            req = 2'($urandom_range(0, 3));
            tick(1);
        end
        rnd_mode = 0; valid = 0;

        // Frequency change in LOCKED re-acquires without a PLL reset.
        en = 0;
        tick(2);
        request(FSEL_X8, 5, w);
        pat = mkpat(3);
        en = 1;
        wait_state(3, 400, "lock_pre_freq", w);
        chk("lock3_err", int'(errc), 3);
        request(FSEL_X4, 5, w);
        chk("chg_sel", int'(sel), 1);
        chk("chg_state", int'(st), 2);
        chk("chg_gate", int'(gate), 0);
        chk("chg_no_rst", int'(pll_rst), 0);
        wait_state(3, 400, "relock", w);
        chk("relock_cycles", w, 256);
        request(FSEL_X4, 5, w);
        tick(2);
        chk("noop_locked", int'(locked), 1);
        chk("noop_state", int'(st), 3);

        // Request during ACQUIRE is held until LOCKED.
        request(FSEL_X8, 5, w);
        chk("acq_ready", int'(ready), 0);
        request(FSEL_X2, 400, w);
        chk("held_cycles", w, 256);
        chk("held_sel", int'(sel), 2);
        chk("held_state", int'(st), 2);
        tick(100);

        // Asynchronous reset mid-ACQUIRE.
        #2 rst_n = 0;
        #1;
        chk("arst_state", int'(st), 0);
        chk("arst_pll_rst", int'(pll_rst), 1);
        chk("arst_sel", int'(sel), 0);
        chk("arst_err", int'(errc), 0);
        chk("arst_ready", int'(ready), 1);
        @(negedge clk) rst_n = 1;

        // Heavy error while locked.
        pat = mkpat(3);
        restart_run();
        wait_state(3, 600, "lock_pre_loss", w);
        pat = mkpat(40);
        tick(64 * 7);
        chk("loss_err", int'(errc), 40);
`ifdef DPLL_CTRL_LOSS_MON_EN
        chk("loss_locked", int'(locked), 0);
        chk("loss_state", int'(st), 2);
`else
        chk("loss_locked", int'(locked), 1);
        chk("loss_state", int'(st), 3);
`endif
        en = 0;
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
